systolic_feeder: RTL

Upstream sequencer for the 3x3 8-bit systolic array. Accepts one complete A/B matrix pair through a valid/ready handshake and clears the array's accumulators. Streams A columns and B rows into the array one beat per cycle, then drives zeros until the array flags its result. Captures the 144-bit C result and presents it downstream with a valid/ready handshake.

---
 rtl/systolic_feeder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// Sequencer for a 3x3 8-bit systolic array: takes one A/B job, clears the array,
// streams three beats, waits for the array's result and hands it downstream.
module systolic_feeder #(
  parameter int DRAIN_TIMEOUT = 16,
  parameter int TCNT_W        = 5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_job_valid,
  output logic         o_job_ready,
  input  logic [71:0]  i_mat_a,
  input  logic [71:0]  i_mat_b,
  output logic         o_arr_rst_n,
  output logic [23:0]  o_arr_A,
  output logic [23:0]  o_arr_B,
  input  logic [143:0] i_arr_C,
  input  logic         i_arr_C_valid,
  output logic         o_res_valid,
  input  logic         i_res_ready,
  output logic [143:0] o_res_C,
  output logic         o_busy,
  output logic         o_timeout
);

  typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, RESULT} state_t;

  state_t              state;
  logic [71:0]         a_q;
  logic [71:0]         b_q;
  logic [1:0]          k;
  logic [TCNT_W-1:0]   tcnt;

  // Column k of A, one byte per array row: {A[2][k],A[1][k],A[0][k]}.
  function automatic logic [23:0] a_col(input logic [71:0] m, input logic [1:0] col);
    logic [23:0] beat;
    beat = '0;
    for (int r = 0; r < 3; r++) beat[8*r +: 8] = m[8*(3*r + int'(col)) +: 8];
    return beat;
  endfunction

  // Row k of B is already contiguous in the row-major packing.
  function automatic logic [23:0] b_row(input logic [71:0] m, input logic [1:0] row);
    return m[24*int'(row) +: 24];
  endfunction

  // NOTE: the matrix holding registers have no reset; they are only read after a handshake loads them.
  always_ff @(posedge i_clk) begin
    if (state == IDLE && i_job_valid) begin
      a_q <= i_mat_a;
      b_q <= i_mat_b;
    end
  end

  // NOTE: every output is a register written here with <=, so no input reaches an output combinationally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      k           <= '0;
      tcnt        <= '0;
      o_job_ready <= 1'b1;
      o_arr_rst_n <= 1'b0;
      o_arr_A     <= '0;
      o_arr_B     <= '0;
      o_res_valid <= 1'b0;
      o_res_C     <= '0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          o_arr_rst_n <= 1'b1;
          if (i_job_valid) begin
            state       <= CLR;
            o_job_ready <= 1'b0;
            o_busy      <= 1'b1;
            o_arr_rst_n <= 1'b0;
          end
        end
        CLR: begin
          state       <= FEED;
          k           <= 2'd0;
          o_arr_rst_n <= 1'b1;
          o_arr_A     <= a_col(a_q, 2'd0);
          o_arr_B     <= b_row(b_q, 2'd0);
        end
        FEED: begin
          if (k == 2'd2) begin
            state   <= DRAIN;
            tcnt    <= '0;
            o_arr_A <= '0;
            o_arr_B <= '0;
          end else begin
            k       <= k + 2'd1;
            o_arr_A <= a_col(a_q, k + 2'd1);
            o_arr_B <= b_row(b_q, k + 2'd1);
          end
        end
        DRAIN: begin
          // A valid in the last allowed cycle still wins over the abort.
          if (i_arr_C_valid) begin
            state       <= RESULT;
            o_res_C     <= i_arr_C;
            o_res_valid <= 1'b1;
          end else if (tcnt == TCNT_W'(DRAIN_TIMEOUT - 1)) begin
            state       <= IDLE;
            o_timeout   <= 1'b1;
            o_busy      <= 1'b0;
            o_job_ready <= 1'b1;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        RESULT: begin
          if (i_res_ready) begin
            state       <= IDLE;
            o_res_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_job_ready <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          o_job_ready <= 1'b1;
          o_arr_rst_n <= 1'b1;
          o_arr_A     <= '0;
          o_arr_B     <= '0;
          o_res_valid <= 1'b0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
